// File: rtl/fp_multiplier_seq_if.sv
// Handshake bundle for fp_multiplier_seq: operand channel in, result channel out.
interface fp_multiplier_seq_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dataR;
  logic [4:0]   casesspecial;

  modport master (
    output in_valid, dataA, dataB, out_ready,
    input  in_ready, out_valid, dataR, casesspecial
  );

  modport slave (
    input  in_valid, dataA, dataB, out_ready,
    output in_ready, out_valid, dataR, casesspecial
  );
endinterface

// File: rtl/fp_multiplier_seq.sv
// Sequential floating-point multiplier: one shift-add step per clock, then normalise.
// Optional round-to-nearest-even is enabled by defining FPMUL_ROUND_EN; otherwise truncates.
module fp_multiplier_seq #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic               clk,
  input  logic               reset,
  fp_multiplier_seq_if.slave bus
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam int unsigned CW = $clog2(MAN_W + 1);
  localparam int unsigned EW = EXP_W + 2;
  localparam logic [EW-1:0] Bias   = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] ExpMax = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_t;

  state_t              r_state, w_state_next;
  logic [CW-1:0]       r_cnt;
  logic [MAN_W:0]      r_mcand, r_mplier;
  logic [PW-1:0]       r_acc;
  logic                r_sign;
  logic [EXP_W-1:0]    r_ea, r_eb;
  logic [W-1:0]        r_data_r;
  logic [4:0]          r_flags;

  // Operand classification at the input port
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_ma, w_mb;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic             w_sign, w_accept, w_special;
  logic [W-1:0]     w_spec_data;
  logic [4:0]       w_spec_flags;

  assign w_ea     = bus.dataA[W-2:MAN_W];
  assign w_eb     = bus.dataB[W-2:MAN_W];
  assign w_ma     = bus.dataA[MAN_W-1:0];
  assign w_mb     = bus.dataB[MAN_W-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) && (w_ma == '0);
  assign w_b_inf  = (&w_eb) && (w_mb == '0);
  assign w_a_nan  = (&w_ea) && (|w_ma);
  assign w_b_nan  = (&w_eb) && (|w_mb);
  assign w_sign   = bus.dataA[W-1] ^ bus.dataB[W-1];
  assign w_accept = bus.in_valid && bus.in_ready;

  // Special-case result; first matching class wins
  always_comb begin
    w_special    = 1'b1;
    w_spec_data  = '0;
    w_spec_flags = 5'b00000;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_spec_data  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      w_spec_flags = 5'b00001;
    end else if (w_a_inf || w_b_inf) begin
      w_spec_data  = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_spec_flags = w_sign ? 5'b00010 : 5'b00100;
    end else if (w_a_zero || w_b_zero) begin
      w_spec_data  = {w_sign, {(W-1){1'b0}}};
      w_spec_flags = w_sign ? 5'b01000 : 5'b10000;
    end else begin
      w_special    = 1'b0;
    end
  end

  // Shift-add step: add multiplicand into the upper half, then shift the accumulator right
  logic [MAN_W+1:0] w_sum;
  assign w_sum = {1'b0, r_acc[PW-1:MAN_W+1]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);

  // Normalisation: bring the leading one to the top bit of w_norm
  logic             w_msb, w_carry;
  logic [PW-1:0]    w_norm;
  logic [MAN_W-1:0] w_man, w_man_fin;
  logic [EW-1:0]    w_e;
  logic [W-1:0]     w_norm_data;
  logic [4:0]       w_norm_flags;

  assign w_msb  = r_acc[PW-1];
  assign w_norm = w_msb ? r_acc : {r_acc[PW-2:0], 1'b0};
  assign w_man  = w_norm[PW-2:MAN_W+1];

`ifdef FPMUL_ROUND_EN
  logic             w_guard, w_sticky, w_round_up, w_unused_norm;
  logic [MAN_W:0]   w_man_sum;
  assign w_guard       = w_norm[MAN_W];
  assign w_sticky      = |w_norm[MAN_W-1:0];
  assign w_round_up    = w_guard && (w_sticky || w_man[0]);
  assign w_man_sum     = {1'b0, w_man} + (MAN_W+1)'(w_round_up);
  // A carry out means 1.11..1 rounded to 10.00..0: mantissa wraps to zero, exponent bumps
  assign w_man_fin     = w_man_sum[MAN_W-1:0];
  assign w_carry       = w_man_sum[MAN_W];
  assign w_unused_norm = w_norm[PW-1];
`else
  logic w_unused_norm;
  assign w_man_fin     = w_man;
  assign w_carry       = 1'b0;
  assign w_unused_norm = ^{w_norm[PW-1], w_norm[MAN_W:0]};
`endif

  assign w_e = {2'b00, r_ea} + {2'b00, r_eb} - Bias + EW'(w_msb) + EW'(w_carry);

  // Range check of the biased exponent: top bit set means negative
  always_comb begin
    w_norm_data  = {r_sign, w_e[EXP_W-1:0], w_man_fin};
    w_norm_flags = 5'b00000;
    if (!w_e[EW-1] && (w_e >= ExpMax)) begin
      w_norm_data  = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_norm_flags = r_sign ? 5'b00010 : 5'b00100;
    end else if (w_e[EW-1] || (w_e == '0)) begin
      w_norm_data  = {r_sign, {(W-1){1'b0}}};
      w_norm_flags = r_sign ? 5'b01000 : 5'b10000;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_next = w_special ? StDone : StMul;
      StMul:   if (r_cnt == CW'(MAN_W)) w_state_next = StNorm;
      StNorm:  w_state_next = StDone;
      StDone:  if (bus.out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath registers: operand latch, iteration, result load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_sign   <= 1'b0;
      r_ea     <= '0;
      r_eb     <= '0;
      r_data_r <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_sign   <= w_sign;
            r_ea     <= w_ea;
            r_eb     <= w_eb;
            r_mcand  <= {1'b1, w_ma};
            r_mplier <= {1'b1, w_mb};
            r_acc    <= '0;
            r_cnt    <= '0;
            if (w_special) begin
              r_data_r <= w_spec_data;
              r_flags  <= w_spec_flags;
            end
          end
        end
        StMul: begin
          r_acc    <= {w_sum, r_acc[MAN_W:1]};
          r_mplier <= r_mplier >> 1;
          r_cnt    <= (r_cnt == CW'(MAN_W)) ? '0 : r_cnt + 1'b1;
        end
        StNorm: begin
          r_data_r <= w_norm_data;
          r_flags  <= w_norm_flags;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = (r_state == StIdle) && !reset;
  assign bus.out_valid    = (r_state == StDone);
  assign bus.dataR        = r_data_r;
  assign bus.casesspecial = r_flags;
endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Directed bench for fp_multiplier_seq (FP32), with hand-computed expected results.
module tb_fp_multiplier_seq;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  fp_multiplier_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_multiplier_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; lat = expected edges from accept to out_valid, hold = stall cycles
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [4:0] f, input int lat,
                        input int hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready before"}, 32'(bus.in_ready), 32'd1);
    bus.dataA    = a;
    bus.dataB    = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dataA    = 32'h0;
    bus.dataB    = 32'h0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 100);
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " dataR"}, bus.dataR, r);
    check({tag, " flags"}, 32'(bus.casesspecial), 32'(f));
    check({tag, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, " hold dataR"}, bus.dataR, r);
      check({tag, " hold flags"}, 32'(bus.casesspecial), 32'(f));
      check({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " out_valid after"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready after"}, 32'(bus.in_ready), 32'd1);
    check({tag, " dataR retained"}, bus.dataR, r);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dataA     = 32'h0;
    bus.dataB     = 32'h0;

    repeat (2) @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset dataR", bus.dataR, 32'h0);
    check("reset flags", 32'(bus.casesspecial), 32'd0);
    reset = 1'b0;

    run_op("7.875x0.1875", 32'h40FC0000, 32'h3E400000, 32'h3FBD0000, 5'b00000, 25, 0);
    run_op("-18x9.5", 32'hC1900000, 32'h41180000, 32'hC32B0000, 5'b00000, 25, 10);
    run_op("inf x 0", 32'h7F800000, 32'h00000000, 32'h7FC00000, 5'b00001, 1, 0);
    run_op("-inf x 9.5", 32'hFF800000, 32'h41180000, 32'hFF800000, 5'b00010, 1, 0);
    run_op("0 x -0", 32'h00000000, 32'h80000000, 32'h80000000, 5'b01000, 1, 0);
    run_op("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000, 5'b00100, 25, 0);
`ifdef FPMUL_ROUND_EN
    run_op("tie rne", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 5'b00000, 25, 0);
`else
    run_op("tie trunc", 32'h3F800001, 32'h3FC00000, 32'h3FC00001, 5'b00000, 25, 0);
`endif

    // Abort an operation with reset partway through the shift-add loop
    @(negedge clk);
    bus.dataA    = 32'h40FC0000;
    bus.dataB    = 32'h3E400000;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("abort busy in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("abort in_ready", 32'(bus.in_ready), 32'd0);
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort dataR", bus.dataR, 32'h0);
    check("abort flags", 32'(bus.casesspecial), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("post-abort out_valid", 32'(bus.out_valid), 32'd0);
    end
    check("post-abort dataR", bus.dataR, 32'h0);
    check("post-abort in_ready", 32'(bus.in_ready), 32'd1);

    run_op("after reset", 32'h40FC0000, 32'h3E400000, 32'h3FBD0000, 5'b00000, 25, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_multiplier_seq.md
# fp_multiplier_seq

Parametrised, sequential IEEE-754-style floating-point multiplier with valid/ready handshakes on input and output. The mantissa product is built with an iterative shift-add datapath instead of a single wide combinational multiplier, which trades latency for area. It then normalises the product, handles exponent overflow and underflow, optionally rounds to nearest-even, and reports special cases on a one-hot flag vector. It sits between the operand register file and the result bus of the FP datapath and replaces the combinational FP32 multiplier unit.

## Interface
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23, stored mantissa width; the hidden bit is implicit.
- Word width W = 1+EXP_W+MAN_W.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands are present on dataA/dataB.
- in_ready  out  1  block accepts operands; high only in IDLE and never while reset is high.
- dataA  in  W  operand A as {sign, exponent, mantissa}.
- dataB  in  W  operand B.
- out_valid  out  1  dataR and casesspecial hold a result.
- out_ready  in  1  consumer takes the result.
- dataR  out  W  product.
- casesspecial  out  5  one-hot flags; bit4 +zero, bit3 -zero, bit2 +inf, bit1 -inf, bit0 NaN; 00000 means a normal result.

## Operation
- FSM states: IDLE, MUL, NORM, DONE.
- Acceptance happens when in_valid && in_ready. Operands are latched and sign = signA ^ signB.
- Classification at acceptance. Exponent 0 is treated as zero; denormals are flushed. First matching rule wins:
  - NaN: either operand is NaN, or one operand is inf and the other is zero. Result 0x7FC00000-style canonical quiet NaN: sign 0, exponent all ones, mantissa MSB 1, rest 0. Flag bit0.
  - inf: either operand is inf. Result {sign, all ones, 0}. Flag bit1 if sign else bit2.
  - zero: either operand is zero. Result {sign, 0, 0}. Flag bit3 if sign else bit4.
  - For any special case, the FSM goes IDLE -> DONE directly.
- Normal operands, IDLE -> MUL:
  - Multiplicand {1, manA}; multiplier {1, manB}.
  - One multiplier bit is processed per clock, LSB first, into a (2*MAN_W+2)-bit accumulator.
  - Iteration counter 0..MAN_W. After MAN_W+1 iterations the FSM goes to NORM.
- NORM (one cycle):
  - Compute e = eA + eB - bias in EXP_W+2 bits, signed.
  - If the product MSB is 1: shift right by one and increment e.
  - Apply rounding per Configuration. If rounding carries out of the mantissa, renormalise and increment e.
  - If e >= 2^EXP_W - 1: result is ±inf with the inf flag.
  - If e <= 0: result is signed zero with the zero flag.
  - Otherwise: {sign, e[EXP_W-1:0], mantissa}, flags 00000.
- DONE: out_valid = 1. dataR and casesspecial are held stable until out_ready, then the FSM returns to IDLE.

## Timing
- Reset values: FSM IDLE, counter 0, out_valid 0, dataR 0, casesspecial 00000, in_ready 0 while reset is high.
- Normal-operand latency: out_valid rises MAN_W+2 clock edges after the accepting edge. For FP32 that is 25 edges.
- Special-case latency: out_valid rises 1 edge after the accepting edge.
- Throughput: one operation in flight. in_ready is low in MUL, NORM and DONE.
- After the handshake edge in DONE, in_ready = 1 in the next cycle, giving a one-cycle bubble.
- Backpressure: DONE holds indefinitely while out_ready = 0. Outputs must not change during the hold.
- out_ready has no effect outside DONE. in_valid is ignored unless in_ready = 1.
- Reset asserted mid-operation aborts immediately. The partial result is discarded and no out_valid pulse appears.
- dataR and casesspecial retain their last value after leaving DONE and until the next result loads.

## Configuration
- FPMUL_ROUND_EN defined:
  - Round-to-nearest-even using guard, round and sticky bits taken from the discarded product bits.
  - A tie rounds up only when the mantissa LSB is 1.
- FPMUL_ROUND_EN undefined:
  - Truncation; discarded bits are dropped.
  - The rounding adder and the renormalise-on-carry path are removed.
  - Latency is unchanged.

## Test plan
- 0x40FC0000 × 0x3E400000 (7.875 × 0.1875) -> dataR 0x3FBD0000, flags 00000, out_valid exactly 25 edges after accept.
- 0xC1900000 × 0x41180000 (-18 × 9.5) -> 0xC32B0000, flags 00000.
- Special cases, each with out_valid 1 edge after accept:
  - 0x7F800000 × 0x00000000 -> 0x7FC00000, flags 00001.
  - 0xFF800000 × 0x41180000 -> 0xFF800000, flags 00010.
  - 0x00000000 × 0x80000000 -> 0x80000000, flags 01000.
- Overflow: 0x7F000000 × 0x40000000 -> 0x7F800000, flags 00100.
- Rounding tie: 0x3F800001 × 0x3FC00000 -> 0x3FC00002 with FPMUL_ROUND_EN, 0x3FC00001 without.
- Handshake and reset:
  - Hold out_ready = 0 for 10 cycles in DONE -> outputs stable and in_ready = 0 throughout.
  - Assert reset at MUL iteration 10 -> out_valid stays 0 and all outputs return to their reset values.
  - Next operation after reset -> correct result.
